// File: rtl/dual_seg7_ctrl.sv
// dual_seg7_ctrl
//   Sequencing controller for the dual seven-segment display pair. After reset
//   it runs a lamp test for LAMP_CYCLES cycles. It then accepts display values
//   over a valid/ready handshake. While blink_req is high it can blink the
//   shown value.
//
// Optional feature macro: DUAL_SEG7_BLINK_EN
//   Defined:   blink counter and phase register are built, and blink_req is honoured.
//   Undefined: no blink logic is built, blink_req is ignored, and SHOW keeps blank=0.
//
// Parameters
//   LAMP_CYCLES  post-reset lamp test length in cycles (>= 1)
//   BLINK_HALF   blink half-period in cycles (>= 1)
//
// Ports
//   clk         single clock, rising edge
//   reset       synchronous active-high reset
//   load_valid  new display value offered
//   load_data   offered value, [7:4] upper digit, [3:0] lower digit
//   load_ready  controller accepts a value this cycle
//   blink_req   level, blink the shown value while high
//   test_req    level, manual lamp test while high
//   push_out    value to the display pair
//   blank       blank request to both digits
//   test        lamp-test request to both digits
//   state_o     current state (LAMP=0, IDLE=1, SHOW=2)
//
// state | meaning
// ------+----------------------------------------------------------
// LAMP  | power-on lamp test, test=1, handshake closed
// IDLE  | waiting for the first value, display blanked
// SHOW  | showing the latched value, blank follows the blink phase

module dual_seg7_ctrl #(
  parameter int LAMP_CYCLES = 25_000_000,
  parameter int BLINK_HALF  = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  input  logic       blink_req,
  input  logic       test_req,
  output logic [7:0] push_out,
  output logic       blank,
  output logic       test,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    ST_LAMP = 2'd0,
    ST_IDLE = 2'd1,
    ST_SHOW = 2'd2
  } state_t;

  localparam int LAMP_W = $clog2(LAMP_CYCLES + 1);
  localparam logic [LAMP_W-1:0] LAMP_LAST = LAMP_W'(LAMP_CYCLES - 1);

  state_t            state_q;
  logic [LAMP_W-1:0] lamp_cnt_q;
  logic [7:0]        push_q;
  logic              blank_q;
  logic              test_q;
  logic              ready_q;

  logic accept;
  logic show_blank_d;

  assign accept = load_valid && ready_q;

`ifdef DUAL_SEG7_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_HALF + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;

  // An accept always restarts the blink from the visible phase, even when it
  // coincides with a terminal count.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (state_q != ST_SHOW || accept || !blink_req) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    end
  end

  assign show_blank_d = phase_d;
`else
  logic unused_cfg;
  assign unused_cfg   = blink_req | (BLINK_HALF == 0);
  assign show_blank_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_LAMP;
      lamp_cnt_q <= '0;
      push_q     <= 8'h00;
      blank_q    <= 1'b0;
      test_q     <= 1'b1;
      ready_q    <= 1'b0;
`ifdef DUAL_SEG7_BLINK_EN
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
`endif
    end else begin
`ifdef DUAL_SEG7_BLINK_EN
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
`endif
      case (state_q)
        ST_LAMP: begin
          if (lamp_cnt_q == LAMP_LAST) begin
            state_q    <= ST_IDLE;
            lamp_cnt_q <= '0;
            blank_q    <= 1'b1;
            ready_q    <= 1'b1;
            test_q     <= test_req;
          end else begin
            lamp_cnt_q <= lamp_cnt_q + LAMP_W'(1);
          end
        end
        ST_IDLE: begin
          test_q <= test_req;
          if (accept) begin
            state_q <= ST_SHOW;
            push_q  <= load_data;
            blank_q <= show_blank_d;
          end else begin
            blank_q <= 1'b1;
          end
        end
        ST_SHOW: begin
          test_q  <= test_req;
          blank_q <= show_blank_d;
          if (accept) push_q <= load_data;
        end
        default: begin
          state_q    <= ST_LAMP;
          lamp_cnt_q <= '0;
          blank_q    <= 1'b0;
          test_q     <= 1'b1;
          ready_q    <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready = ready_q;
  assign push_out   = push_q;
  assign blank      = blank_q;
  assign test       = test_q;
  assign state_o    = state_q;

endmodule
